// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ssd_pkg;

  localparam int NUM_DIGITS = 4;

  // All segments dark (active-low cathodes) and all anodes off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low seven-segment pattern lookup.
// Latency: purely combinational.
// Backpressure: none.
module hex_to_seg7
  import ssd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7_TABLE[nib_i];

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed hex display driver with a per-frame shadow of the shown half-word.
// Latency: outputs lag the digit counter / shadow by one cycle; first digit lit on 2nd edge after reset.
// Backpressure: none; value is sampled blindly at each frame boundary.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic        half_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int         DIG_W    = $clog2(NUM_DIGITS);
  localparam logic [19:0] DIV_LAST = 20'(REFRESH_DIV - 1);

  logic [19:0]      div_cnt_q, div_cnt_d;
  logic [DIG_W-1:0] dig_idx_q, dig_idx_d;
  logic [15:0]      shadow_q,  shadow_d;
  logic             half_q,    half_d;
  logic             primed_q,  primed_d;
  logic             frame_tick_q, frame_tick_d;
  logic [3:0]       an_q,  an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q,  dp_d;

  logic             div_last;
  logic             load;
  logic [3:0]       cur_nib;
  logic [6:0]       cur_seg;

  // A digit period ends on the last divider count; the frame ends when that hits digit 3.
  assign div_last = (div_cnt_q == DIV_LAST);
  assign load     = !primed_q || (div_last && (dig_idx_q == DIG_W'(NUM_DIGITS - 1)));
  assign cur_nib  = shadow_q[{dig_idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nib_i (cur_nib),
    .seg_o (cur_seg)
  );

  // Next state of divider, digit counter and the frame shadow.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    dig_idx_d    = dig_idx_q;
    shadow_d     = shadow_q;
    half_d       = half_q;
    primed_d     = 1'b1;
    frame_tick_d = load;
    // The priming edge only captures the word; counting starts on the following edge.
    if (primed_q) begin
      if (div_last) begin
        div_cnt_d = '0;
        dig_idx_d = dig_idx_q + DIG_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + 20'd1;
      end
    end
    if (load) begin
      shadow_d = half_sel ? value[31:16] : value[15:0];
      half_d   = half_sel;
    end
  end

  // Next value of the registered display outputs; held blank until primed.
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (primed_q) begin
      an_d  = ~(4'b0001 << dig_idx_q);
      seg_d = cur_seg;
      dp_d  = ~(half_q && (dig_idx_q == '0));
    end
  end

  // State and output registers; reset blanks the display asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      dig_idx_q    <= '0;
      shadow_q     <= '0;
      half_q       <= 1'b0;
      primed_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      div_cnt_q    <= div_cnt_d;
      dig_idx_q    <= dig_idx_d;
      shadow_q     <= shadow_d;
      half_q       <= half_d;
      primed_q     <= primed_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = 32'h0;
  logic        half_sel = 1'b0;

  logic [3:0]  an4, an1;
  logic [6:0]  seg4, seg1;
  logic        dp4, dp1;
  logic        ft4, ft1;

  int tests_run = 0;
  int tests_failed = 0;

  // Hand-derived patterns, indexed by digit position 0..3.
  logic [6:0] lower_seg [4] = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000}; // D C B A
  logic [6:0] upper_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}; // 4 3 2 1
  logic [3:0] an_pat    [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  ssd_scan_driver #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .value(value), .half_sel(half_sel),
    .an(an4), .seg(seg4), .dp(dp4), .frame_tick(ft4)
  );

  ssd_scan_driver #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .value(value), .half_sel(half_sel),
    .an(an1), .seg(seg1), .dp(dp1), .frame_tick(ft1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset, apply inputs, release between edges; next edge is the prime edge.
  task automatic restart(input logic [31:0] v, input logic h);
    rst_n = 1'b0;
    step();
    value = v;
    half_sel = h;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    value = 32'h0;
    half_sel = 1'b0;
    step();
    step();
    tests_run++; if (an4 !== 4'b1111) begin tests_failed++; $display("FAIL reset_an got %b exp 1111", an4); end
    tests_run++; if (seg4 !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg got %b exp 1111111", seg4); end
    tests_run++; if (dp4 !== 1'b1) begin tests_failed++; $display("FAIL reset_dp got %b exp 1", dp4); end
    tests_run++; if (ft4 !== 1'b0) begin tests_failed++; $display("FAIL reset_ft got %b exp 0", ft4); end
    @(negedge clk);
    rst_n = 1'b1;
    step(); // edge 1: prime
    tests_run++; if (ft4 !== 1'b1) begin tests_failed++; $display("FAIL prime_ft got %b exp 1", ft4); end
    tests_run++; if (an4 !== 4'b1111) begin tests_failed++; $display("FAIL prime_an got %b exp 1111", an4); end
    step(); // edge 2: first digit lit
    tests_run++; if (an4 !== 4'b1110) begin tests_failed++; $display("FAIL edge2_an got %b exp 1110", an4); end
    tests_run++; if (seg4 !== 7'b1000000) begin tests_failed++; $display("FAIL edge2_seg got %b exp 1000000", seg4); end
    tests_run++; if (ft4 !== 1'b0) begin tests_failed++; $display("FAIL edge2_ft got %b exp 0", ft4); end
  endtask

  // Walk one full frame; frame_tick must rise only after the final cycle of digit 3.
  task automatic test_half(input logic h);
    restart(32'h1234ABCD, h);
    step();
    step();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        tests_run++;
        if (an4 !== an_pat[d]) begin tests_failed++; $display("FAIL half%0d_an d%0d c%0d got %b exp %b", h, d, c, an4, an_pat[d]); end
        tests_run++;
        if (seg4 !== (h ? upper_seg[d] : lower_seg[d])) begin
          tests_failed++; $display("FAIL half%0d_seg d%0d c%0d got %b exp %b", h, d, c, seg4, h ? upper_seg[d] : lower_seg[d]);
        end
        tests_run++;
        if (dp4 !== ((h && d == 0) ? 1'b0 : 1'b1)) begin tests_failed++; $display("FAIL half%0d_dp d%0d c%0d got %b", h, d, c, dp4); end
        tests_run++;
        if (ft4 !== ((d == 3 && c == 3) ? 1'b1 : 1'b0)) begin tests_failed++; $display("FAIL half%0d_ft d%0d c%0d got %b", h, d, c, ft4); end
        if (!(d == 3 && c == 3)) step();
      end
    end
  endtask

  task automatic test_tear_free();
    restart(32'h1234ABCD, 1'b0);
    step();
    step();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (d > 0) begin
          tests_run++;
          if (seg4 !== lower_seg[d]) begin tests_failed++; $display("FAIL tear_seg d%0d c%0d got %b exp %b", d, c, seg4, lower_seg[d]); end
        end
        if (d == 1 && c == 1) value = 32'hFFFF0000;
        if (!(d == 3 && c == 3)) step();
      end
    end
    tests_run++; if (ft4 !== 1'b1) begin tests_failed++; $display("FAIL tear_ft got %b exp 1", ft4); end
    step();
    tests_run++; if (an4 !== 4'b1110) begin tests_failed++; $display("FAIL tear_new_an got %b exp 1110", an4); end
    tests_run++; if (seg4 !== 7'b1000000) begin tests_failed++; $display("FAIL tear_new_seg got %b exp 1000000", seg4); end
  endtask

  task automatic test_async_reset();
    restart(32'h1234ABCD, 1'b0);
    step();
    step();
    for (int i = 0; i < 9; i++) step(); // now inside digit 2
    tests_run++; if (an4 !== 4'b1011) begin tests_failed++; $display("FAIL mid_an got %b exp 1011", an4); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (an4 !== 4'b1111) begin tests_failed++; $display("FAIL arst_an got %b exp 1111", an4); end
    tests_run++; if (seg4 !== 7'h7F) begin tests_failed++; $display("FAIL arst_seg got %b exp 1111111", seg4); end
    tests_run++; if (dp4 !== 1'b1) begin tests_failed++; $display("FAIL arst_dp got %b exp 1", dp4); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    tests_run++; if (ft4 !== 1'b1) begin tests_failed++; $display("FAIL reprime_ft got %b exp 1", ft4); end
    tests_run++; if (an4 !== 4'b1111) begin tests_failed++; $display("FAIL reprime_an got %b exp 1111", an4); end
    step();
    tests_run++; if (an4 !== 4'b1110) begin tests_failed++; $display("FAIL reprime_an2 got %b exp 1110", an4); end
    tests_run++; if (seg4 !== 7'b0100001) begin tests_failed++; $display("FAIL reprime_seg got %b exp 0100001", seg4); end
  endtask

  // REFRESH_DIV=1: one digit per edge, tick on edges 1, 5, 9.
  task automatic test_div1();
    restart(32'h1234ABCD, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step();
      tests_run++;
      if (ft1 !== ((k == 1 || k == 5 || k == 9) ? 1'b1 : 1'b0)) begin tests_failed++; $display("FAIL div1_ft edge%0d got %b", k, ft1); end
      if (k >= 2) begin
        tests_run++;
        if (an1 !== an_pat[(k-2)%4]) begin tests_failed++; $display("FAIL div1_an edge%0d got %b exp %b", k, an1, an_pat[(k-2)%4]); end
        tests_run++;
        if (seg1 !== lower_seg[(k-2)%4]) begin tests_failed++; $display("FAIL div1_seg edge%0d got %b exp %b", k, seg1, lower_seg[(k-2)%4]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_half(1'b0);
    test_half(1'b1);
    test_tear_free();
    test_async_reset();
    test_div1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
